// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic {
      RUN     = 1'b0,
      DISCARD = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush and occupancy count
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push_i,
   input  fetch_entry_t     data_i,
   input  logic             pop_i,
   output fetch_entry_t     data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // A push into a full queue is still legal when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~clear_i & (count_q != '0);
   assign do_push = push_i & ~clear_i & ((count_q != FULL_CNT) | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_ni && do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - in-order instruction fetch with credit-limited requests,
// a registered {inst, pc} queue to decode, and redirect flush of stale responses.
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(DEPTH);

   fetch_state_e     state_q, state_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      rsp_pc_q, rsp_pc_d;

   logic [CNT_W-1:0] q_count;
   logic             q_empty;
   logic             q_push;
   logic             q_pop;
   fetch_entry_t     q_head;
   fetch_entry_t     q_in;
   logic [CNT_W:0]   credit_used;
   logic             req_fire;
   logic [CNT_W-1:0] rsp_dec;

   // Queued entries plus in-flight requests never exceed DEPTH, so every response has a slot.
   assign credit_used    = {1'b0, q_count} + {1'b0, outstanding_q};
   assign imem_req_valid = rst & ~redirect_valid & (credit_used < CREDIT_MAX);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign rsp_dec        = CNT_W'(imem_rsp_valid);

   assign inst_valid = ~q_empty;
   assign q_pop      = inst_valid & inst_ready;
   assign q_in       = '{inst: imem_rsp_data, pc: rsp_pc_q};
   assign inst_out   = inst_valid ? q_head.inst : NOP_INST;
   assign pc_out     = inst_valid ? q_head.pc : 32'h0000_0000;

   always_comb begin
      state_d       = state_q;
      drop_d        = drop_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      q_push        = 1'b0;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - rsp_dec;

      if (redirect_valid) begin
         // A response landing in the redirect cycle is stale and already accounted for here.
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         drop_d     = outstanding_q - rsp_dec;
         state_d    = (drop_d != '0) ? DISCARD : RUN;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (imem_rsp_valid) begin
            case (state_q)
               RUN: begin
                  q_push   = 1'b1;
                  rsp_pc_d = rsp_pc_q + 32'd4;
               end
               DISCARD: begin
                  drop_d = drop_q - CNT_W'(1);
                  if (drop_q == CNT_W'(1)) begin
                     state_d = RUN;
                  end
               end
               default: begin
                  state_d = RUN;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= RUN;
         outstanding_q <= '0;
         drop_q        <= '0;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clear_i (redirect_valid),
      .push_i  (q_push),
      .data_i  (q_in),
      .pop_i   (q_pop),
      .data_o  (q_head),
      .count_o (q_count),
      .empty_o (q_empty)
   );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue with a variable-latency memory model
module tb_inst_fetch_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] pc_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   int          cyc;
   int          lat;

   int          gen = 0;
   logic [31:0] restart_pc = 32'h0;
   int          pops;
   int          pops_base;
   int          nreq;

   always #5 clk = ~clk;

   inst_fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_out       (inst_out),
      .pc_out         (pc_out)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0003;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // New expected stream starting at pc; the monitor picks it up on its next sample.
   task automatic restart(input logic [31:0] pc);
      restart_pc = pc;
      gen++;
   endtask

   // Memory model: in-order responses, one per cycle, lat cycles after acceptance.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mq.delete();
         end else if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
         end
         @(posedge clk);
         cyc++;
         #1;
         if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
      end
   end

   // Monitor: request address sequence and the scoreboard of delivered instructions.
   initial begin
      logic [31:0] exp_q[$];
      logic [31:0] exp_req_addr;
      logic [31:0] e;
      int          seen_gen;
      seen_gen     = 0;
      exp_req_addr = 32'h0;
      pops         = 0;
      forever begin
         @(negedge clk);
         if (gen != seen_gen) begin
            seen_gen = gen;
            exp_q.delete();
            for (int i = 0; i < 64; i++) begin
               exp_q.push_back(restart_pc + 32'(4 * i));
            end
            exp_req_addr = restart_pc;
         end
         if (imem_req_valid) begin
            chk("req_addr", imem_req_addr, exp_req_addr);
            if (imem_req_ready) begin
               exp_req_addr = exp_req_addr + 32'd4;
            end
         end
         if (inst_valid) begin
            if (inst_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_empty: got pc %h, expected no delivery", pc_out);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_pc", pc_out, e);
                  chk("sb_inst", inst_out, inst_of(e));
                  pops++;
               end
            end
         end else begin
            chk("idle_inst", inst_out, NOP);
            chk("idle_pc", pc_out, 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst_out", inst_out, NOP);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);

      // Release with a 1-cycle memory
      @(posedge clk); #1; rst = 1'b1; restart(32'h0);
      @(negedge clk);
      chk("a_req_c0", imem_req_valid, 1);
      chk("a_iv_c0", inst_valid, 0);
      @(negedge clk);
      chk("a_req_c1", imem_req_valid, 1);
      chk("a_iv_c1", inst_valid, 0);
      @(negedge clk);
      chk("a_req_c2", imem_req_valid, 1);
      chk("a_iv_c2", inst_valid, 1);
      chk("a_pc_c2", pc_out, 32'h0);

      // Request backpressure for 3 cycles
      repeat (4) @(posedge clk);
      #1; imem_req_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("c_req_held", imem_req_valid, 1);
      end
      @(posedge clk); #1; imem_req_ready = 1'b1;
      repeat (8) @(posedge clk);

      // Decode stall from reset: exactly DEPTH requests
      #1; rst = 1'b0; inst_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1; restart(32'h0);
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) nreq++;
      end
      chk("b_req_count", nreq, 4);
      chk("b_req_idle", imem_req_valid, 0);
      chk("b_head_pc", pc_out, 32'h0);
      @(posedge clk); #1; inst_ready = 1'b1; pops_base = pops;
      repeat (8) @(posedge clk);
      chk("b_drained", 32'((pops - pops_base) >= 4), 1);

      // Redirect with two stale requests in a 3-cycle memory
      #1; rst = 1'b0; lat = 3;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1; restart(32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      chk("d_req_suppressed", imem_req_valid, 0);
      @(posedge clk); #1; redirect_valid = 1'b0; restart(32'h100);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("d_iv_wait", inst_valid, 0);
      end
      @(negedge clk);
      chk("d_iv_first", inst_valid, 1);
      chk("d_pc_first", pc_out, 32'h100);
      repeat (6) @(posedge clk);

      // Redirect together with a response and a pop, 2-cycle memory
      #1; rst = 1'b0; lat = 2;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1; restart(32'h0);
      repeat (4) @(posedge clk);
      #1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      @(negedge clk);
      chk("e_iv_at_redirect", inst_valid, 1);
      chk("e_rsp_at_redirect", imem_rsp_valid, 1);
      chk("e_req_suppressed", imem_req_valid, 0);
      @(posedge clk); #1; redirect_valid = 1'b0; restart(32'h200);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("e_iv_wait", inst_valid, 0);
      end
      @(negedge clk);
      chk("e_iv_first", inst_valid, 1);
      chk("e_pc_first", pc_out, 32'h200);

      // Reset with a full queue
      @(posedge clk); #1; inst_ready = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("f_full_iv", inst_valid, 1);
      chk("f_full_noreq", imem_req_valid, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("f_rst_noreq", imem_req_valid, 0);
      @(negedge clk);
      chk("f_rst_iv", inst_valid, 0);
      chk("f_rst_inst", inst_out, NOP);
      chk("f_rst_pc", pc_out, 32'h0);
      chk("f_rst_addr", imem_req_addr, 32'h0);
      @(posedge clk); #1; rst = 1'b1; inst_ready = 1'b1; lat = 1; restart(32'h0);
      pops_base = pops;
      @(negedge clk);
      chk("f_restart_req", imem_req_valid, 1);
      repeat (10) @(posedge clk);
      chk("f_restart_pops", 32'((pops - pops_base) >= 6), 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
